// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined main-memory port between I-cache block fills and D-cache
// fills / write-throughs, steers returned words to the right cache and freezes requesters.
module cache_fill_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_miss,
  input  logic [15:0]                i_addr,
  input  logic                       d_miss,
  input  logic                       d_wr,
  input  logic [15:0]                d_addr,
  input  logic [15:0]                d_wdata,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [15:0]                mem_addr,
  output logic [15:0]                mem_wdata,
  input  logic                       mem_valid,
  input  logic [15:0]                mem_rdata,
  output logic                       i_fill_we,
  output logic                       d_fill_we,
  output logic [$clog2(WORDS)-1:0]   fill_word,
  output logic [15:0]                fill_data,
  output logic                       i_busy,
  output logic                       d_busy,
  output logic                       i_done,
  output logic                       d_done
);

  localparam int               CW        = $clog2(WORDS);
  localparam logic [15:0]      BLK_MASK  = 16'(2 * WORDS - 1);
  localparam logic [CW:0]      ISSUE_END = (CW + 1)'(WORDS);
  localparam logic [CW-1:0]    RECV_LAST = CW'(WORDS - 1);

  if ((MEM_LAT < 1) || (WORDS < 2) || ((WORDS & (WORDS - 1)) != 0)) begin : g_param_check
    $error("cache_fill_arbiter: MEM_LAT must be >= 1 and WORDS a power of two >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_FILL  = 2'd1,
    ST_D_FILL  = 2'd2,
    ST_D_WRITE = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic [CW:0]    issue_cnt_r;
  logic [CW-1:0]  recv_cnt_r;
  logic [15:0]    base_r;
  logic [15:0]    wr_addr_r;
  logic [15:0]    wdata_r;
  logic           last_d_r;
  logic           grant_i_s;
  logic           grant_d_s;
  logic           fill_s;
  logic           issuing_s;
  logic           beat_s;
  logic           last_beat_s;
  logic           write_ack_s;

  // Cycle qualifiers; a beat is only accepted while fewer words were received than issued
  always_comb begin
    fill_s      = (state_r == ST_I_FILL) || (state_r == ST_D_FILL);
    issuing_s   = (fill_s && (issue_cnt_r < ISSUE_END)) ||
                  ((state_r == ST_D_WRITE) && (issue_cnt_r == '0));
    beat_s      = fill_s && mem_valid && ({1'b0, recv_cnt_r} < issue_cnt_r);
    last_beat_s = beat_s && (recv_cnt_r == RECV_LAST);
    write_ack_s = (state_r == ST_D_WRITE) && mem_valid && (issue_cnt_r != '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and round-robin grant: on a tie the side not served last wins
  always_comb begin
    state_nx_s = state_r;
    grant_i_s  = 1'b0;
    grant_d_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_miss && d_miss) begin
          grant_i_s = last_d_r;
          grant_d_s = ~last_d_r;
        end else begin
          grant_i_s = i_miss;
          grant_d_s = d_miss;
        end
        if (grant_i_s) begin
          state_nx_s = ST_I_FILL;
        end else if (grant_d_s) begin
          state_nx_s = d_wr ? ST_D_WRITE : ST_D_FILL;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_I_FILL, ST_D_FILL: begin
        if (last_beat_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_D_WRITE: begin
        if (write_ack_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_D_WRITE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Grant-time latches and issue/receive counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt_r <= '0;
      recv_cnt_r  <= '0;
      base_r      <= 16'h0000;
      wr_addr_r   <= 16'h0000;
      wdata_r     <= 16'h0000;
      last_d_r    <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      issue_cnt_r <= '0;
      recv_cnt_r  <= '0;
      if (grant_i_s) begin
        base_r   <= i_addr & ~BLK_MASK;
        last_d_r <= 1'b0;
      end else if (grant_d_s) begin
        base_r    <= d_addr & ~BLK_MASK;
        wr_addr_r <= d_addr;
        wdata_r   <= d_wdata;
        last_d_r  <= 1'b1;
      end
    end else if (last_beat_s || write_ack_s) begin
      issue_cnt_r <= '0;
      recv_cnt_r  <= '0;
    end else begin
      if (issuing_s) begin
        issue_cnt_r <= issue_cnt_r + (CW + 1)'(1);
      end
      if (beat_s) begin
        recv_cnt_r <= recv_cnt_r + CW'(1);
      end
    end
  end

  // Memory request, fill steering, completion and freeze outputs
  always_comb begin
    mem_en    = issuing_s;
    mem_wr    = issuing_s && (state_r == ST_D_WRITE);
    if (issuing_s && fill_s) begin
      mem_addr  = base_r + 16'({issue_cnt_r, 1'b0});
      mem_wdata = 16'h0000;
    end else if (mem_wr) begin
      mem_addr  = wr_addr_r;
      mem_wdata = wdata_r;
    end else begin
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
    end
    i_fill_we = beat_s && (state_r == ST_I_FILL);
    d_fill_we = beat_s && (state_r == ST_D_FILL);
    fill_word = beat_s ? recv_cnt_r : '0;
    fill_data = beat_s ? mem_rdata : 16'h0000;
    i_done    = last_beat_s && (state_r == ST_I_FILL);
    d_done    = (last_beat_s && (state_r == ST_D_FILL)) || write_ack_s;
    // Gated by rst so every output reads 0 while reset is applied
    i_busy    = rst && i_miss && !i_done;
    d_busy    = rst && d_miss && !d_done;
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: fixed-latency memory model plus request/fill
// scoreboard queues popped by a negedge monitor.
module tb_cache_fill_arbiter;

  localparam int MEM_LAT = 4;
  localparam int WORDS   = 8;
  localparam int WB      = $clog2(WORDS);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_miss = 1'b0;
  logic [15:0]   i_addr = 16'h0000;
  logic          d_miss = 1'b0;
  logic          d_wr = 1'b0;
  logic [15:0]   d_addr = 16'h0000;
  logic [15:0]   d_wdata = 16'h0000;
  logic          mem_en, mem_wr;
  logic [15:0]   mem_addr, mem_wdata;
  logic          mem_valid;
  logic [15:0]   mem_rdata;
  logic          i_fill_we, d_fill_we;
  logic [WB-1:0] fill_word;
  logic [15:0]   fill_data;
  logic          i_busy, d_busy, i_done, d_done;
  logic          inj_valid = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  typedef struct packed {
    logic          side_d;
    logic [WB-1:0] word;
    logic [15:0]   data;
  } fill_t;

  req_t  req_q[$];
  fill_t fill_q[$];
  req_t  mon_r;
  fill_t mon_f;

  logic [MEM_LAT-1:0] vld_p = '0;
  logic [15:0]        dat_p [MEM_LAT];

  cache_fill_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .fill_word(fill_word), .fill_data(fill_data),
    .i_busy(i_busy), .d_busy(d_busy), .i_done(i_done), .d_done(d_done)
  );

  always #5 clk = ~clk;

  // Memory model: response MEM_LAT cycles after the request cycle, data = addr ^ 5A5A
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    vld_p    <= {vld_p[MEM_LAT-2:0], mem_en};
    dat_p[0] <= mem_addr ^ 16'h5A5A;
    for (int k = 1; k < MEM_LAT; k++) dat_p[k] <= dat_p[k-1];
  end

  assign mem_valid = vld_p[MEM_LAT-1] | inj_valid;
  assign mem_rdata = dat_p[MEM_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every request and every fill write must match the queue heads
  always @(negedge clk) begin
    if (mem_en) begin
      check("req_expected", 32'(req_q.size() > 0), 32'd1);
      if (req_q.size() > 0) begin
        mon_r = req_q.pop_front();
        check("mem_addr", 32'(mem_addr), 32'(mon_r.addr));
        check("mem_wr", 32'(mem_wr), 32'(mon_r.wr));
        if (mon_r.wr) check("mem_wdata", 32'(mem_wdata), 32'(mon_r.wdata));
      end
    end
    if (i_fill_we || d_fill_we) begin
      check("fill_expected", 32'(fill_q.size() > 0), 32'd1);
      check("fill_we_onehot", 32'(i_fill_we && d_fill_we), 32'd0);
      if (fill_q.size() > 0) begin
        mon_f = fill_q.pop_front();
        check("fill_side", 32'(d_fill_we), 32'(mon_f.side_d));
        check("fill_word", 32'(fill_word), 32'(mon_f.word));
        check("fill_data", 32'(fill_data), 32'(mon_f.data));
      end
    end
  end

  task automatic push_fill(input logic side_d, input logic [15:0] addr, input int nreq, input int nfill);
    logic [15:0] a;
    for (int k = 0; k < WORDS; k++) begin
      a = (addr & 16'hFFF0) + 16'(2 * k);
      if (k < nreq)  req_q.push_back('{wr: 1'b0, addr: a, wdata: 16'h0000});
      if (k < nfill) fill_q.push_back('{side_d: side_d, word: WB'(k), data: a ^ 16'h5A5A});
    end
  endtask

  task automatic wait_issue(input string tag, output int t);
    t = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_en) begin
        t = cyc;
        break;
      end
    end
    check({tag, "_issue_seen"}, 32'(t >= 0), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic side_d, output int t);
    t = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (side_d ? d_done : i_done) begin
        t = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(t >= 0), 32'd1);
  endtask

  task automatic queues_empty(input string tag);
    check({tag, "_req_q_empty"}, 32'(req_q.size()), 32'd0);
    check({tag, "_fill_q_empty"}, 32'(fill_q.size()), 32'd0);
  endtask

  int t0, t1;

  initial begin
    // Reset with a request pending: everything must read 0
    i_miss = 1'b1;
    i_addr = 16'h1236;
    repeat (2) @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_i_busy", 32'(i_busy), 32'd0);
    check("rst_done", 32'({i_done, d_done}), 32'd0);
    check("rst_fill_we", 32'({i_fill_we, d_fill_we}), 32'd0);
    i_miss = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // I fill at 0x1236: reads 0x1230..0x123E, done 11 cycles after first issue
    push_fill(1'b0, 16'h1236, WORDS, WORDS);
    i_addr = 16'h1236;
    i_miss = 1'b1;
    wait_issue("ifill", t0);
    check("ifill_i_busy_during", 32'(i_busy), 32'd1);
    wait_done("ifill", 1'b0, t1);
    check("ifill_latency", 32'(t1 - t0), 32'd11);
    i_miss = 1'b0;
    @(negedge clk);
    check("ifill_i_busy_after", 32'(i_busy), 32'd0);
    check("ifill_idle_mem_en", 32'(mem_en), 32'd0);
    queues_empty("ifill");

    // Single-word write-through, acknowledged MEM_LAT cycles later
    req_q.push_back('{wr: 1'b1, addr: 16'h0040, wdata: 16'hBEEF});
    d_wr    = 1'b1;
    d_addr  = 16'h0040;
    d_wdata = 16'hBEEF;
    d_miss  = 1'b1;
    wait_issue("dwr", t0);
    check("dwr_d_busy", 32'(d_busy), 32'd1);
    wait_done("dwr", 1'b1, t1);
    check("dwr_latency", 32'(t1 - t0), 32'(MEM_LAT));
    d_miss = 1'b0;
    d_wr   = 1'b0;
    @(negedge clk);
    check("dwr_d_busy_after", 32'(d_busy), 32'd0);
    queues_empty("dwr");

    // Fresh reset (last grant I) then simultaneous requests: D first, then I
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_fill(1'b1, 16'h2000, WORDS, WORDS);
    push_fill(1'b0, 16'h3000, WORDS, WORDS);
    i_addr = 16'h3000;
    d_addr = 16'h2000;
    i_miss = 1'b1;
    d_miss = 1'b1;
    wait_done("tie_d", 1'b1, t1);
    check("tie_i_busy_held", 32'(i_busy), 32'd1);
    d_miss = 1'b0;
    wait_done("tie_i", 1'b0, t1);
    i_miss = 1'b0;
    @(negedge clk);
    queues_empty("tie");

    // Round robin under continuous D demand with I held: D, I, D
    push_fill(1'b1, 16'h4000, WORDS, WORDS);
    push_fill(1'b0, 16'h5000, WORDS, WORDS);
    push_fill(1'b1, 16'h4100, WORDS, WORDS);
    i_addr = 16'h5000;
    d_addr = 16'h4000;
    i_miss = 1'b1;
    d_miss = 1'b1;
    wait_done("rr_d1", 1'b1, t1);
    d_miss = 1'b0;
    @(negedge clk);
    check("rr_i_busy_idle", 32'(i_busy), 32'd1);
    d_addr = 16'h4100;
    d_miss = 1'b1;
    wait_done("rr_i", 1'b0, t1);
    check("rr_d_busy_held", 32'(d_busy), 32'd1);
    i_miss = 1'b0;
    wait_done("rr_d2", 1'b1, t1);
    d_miss = 1'b0;
    @(negedge clk);
    queues_empty("rr");

    // Reset at the 4th issue of an I fill; late responses must be ignored
    push_fill(1'b0, 16'h6000, 4, 0);
    i_addr = 16'h6000;
    i_miss = 1'b1;
    wait_issue("rstmid", t0);
    repeat (3) @(negedge clk);
    #1;
    rst    = 1'b0;
    i_miss = 1'b0;
    #1;
    check("rstmid_mem_en", 32'(mem_en), 32'd0);
    check("rstmid_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("rstmid_late_fill_we", 32'(i_fill_we), 32'd0);
    check("rstmid_fill_data", 32'(fill_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_idle_fill_we", 32'({i_fill_we, d_fill_we}), 32'd0);
    check("rstmid_idle_done", 32'({i_done, d_done}), 32'd0);
    repeat (3) @(negedge clk);
    queues_empty("rstmid");
    push_fill(1'b0, 16'h6000, WORDS, WORDS);
    i_miss = 1'b1;
    wait_issue("restart", t0);
    wait_done("restart", 1'b0, t1);
    check("restart_latency", 32'(t1 - t0), 32'd11);
    i_miss = 1'b0;
    @(negedge clk);
    queues_empty("restart");

    // D fill at the top of the address space: 0xFFF0..0xFFFE
    push_fill(1'b1, 16'hFFF8, WORDS, WORDS);
    d_addr = 16'hFFF8;
    d_miss = 1'b1;
    wait_issue("top", t0);
    wait_done("top", 1'b1, t1);
    check("top_latency", 32'(t1 - t0), 32'd11);
    d_miss = 1'b0;
    @(negedge clk);
    queues_empty("top");

    // Stray response while idle is ignored
    inj_valid = 1'b1;
    @(negedge clk);
    check("stray_fill_we", 32'({i_fill_we, d_fill_we}), 32'd0);
    check("stray_done", 32'({i_done, d_done}), 32'd0);
    inj_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Sequences the single shared main-memory port between instruction-cache misses from the fetch stage and data-cache misses and writes from the memory stage.
- Issues pipelined block-fill reads and single-word write-through requests, then steers returned words into the correct cache.
- Drives the stall (freeze) signals that hold the fetch and memory stages while their request is outstanding.

Parameters:
- MEM_LAT, 4: fixed cycles from a request accepted on mem_en to its mem_valid pulse.
- WORDS, 8: 16-bit words per cache block (16-byte block). Must be a power of two.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- i_miss  in  1  I-cache miss, held until i_done.
- i_addr  in  16  I-cache miss byte address.
- d_miss  in  1  D-cache request (miss or write), held until d_done.
- d_wr  in  1  1 = single-word write, 0 = block fill; qualified by d_miss.
- d_addr  in  16  D-side byte address.
- d_wdata  in  16  write data.
- mem_en  out  1  memory request strobe, one request per cycle.
- mem_wr  out  1  request is a write.
- mem_addr  out  16  request byte address.
- mem_wdata  out  16  write data to memory.
- mem_valid  in  1  response pulse; for reads carries mem_rdata, for writes is the acknowledge.
- mem_rdata  in  16  read data.
- i_fill_we  out  1  write returned word into I-cache.
- d_fill_we  out  1  write returned word into D-cache.
- fill_word  out  log2(WORDS)  word index within block.
- fill_data  out  16  returned word (= mem_rdata).
- i_busy  out  1  freeze for fetch stage.
- d_busy  out  1  freeze for memory stage.
- i_done  out  1  one-cycle I-side completion pulse.
- d_done  out  1  one-cycle D-side completion pulse.

Behaviour:
- States: IDLE, I_FILL, D_FILL, D_WRITE.
- Reset (rst=0, any time, including mid-fill):
  - state=IDLE; issue_cnt=0; recv_cnt=0; last_grant=I.
  - All outputs 0; mem_addr=0.
  - An in-flight mem_valid arriving after reset is ignored.
- IDLE grant, decided at the clock edge:
  - If only one side requests, grant it.
  - If both request, grant the side not equal to last_grant (round-robin), so neither side starves.
  - D grant: d_wr=1 goes to D_WRITE, otherwise D_FILL.
  - On grant: latch base = addr & ~(2*WORDS-1); latch d_wdata; set last_grant.
  - mem_valid received in IDLE is ignored.
- Busy flags:
  - i_busy = i_miss & ~i_done; d_busy = d_miss & ~d_done.
  - A requester waiting in IDLE or while the other side is served therefore remains frozen.
- I_FILL / D_FILL:
  - mem_en=1, mem_wr=0 while issue_cnt<WORDS; mem_addr = base + 2*issue_cnt; issue_cnt increments each cycle (first request in the cycle after grant).
  - On each mem_valid: the granted side's *_fill_we=1, fill_word=recv_cnt, fill_data=mem_rdata; recv_cnt increments.
  - On mem_valid with recv_cnt==WORDS-1: assert *_done combinationally that cycle, clear both counters, return to IDLE.
  - Fill latency from grant edge to done = WORDS+MEM_LAT-1 cycles after first issue.
  - Address wraps modulo 2^16 with no carry-out handling (block aligned, so never mid-block).
- D_WRITE:
  - One cycle with mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=latched data.
  - Then wait; d_done pulses with the ack mem_valid; return to IDLE.
  - No fill_we asserted.
- Requests arriving while not IDLE are held by the requester and arbitrated on return to IDLE.
  - Done-to-next-grant gap is 1 cycle minimum (the IDLE cycle).
- The requester must drop *_miss in the cycle after *_done.
  - If it is still high, it is treated as a new request.
- mem_valid count is never greater than issued requests; an excess mem_valid is ignored (recv_cnt saturates at WORDS-1 path).

Test Plan:
- Reset, then i_miss=1, i_addr=0x1236 -> mem reads 0x1230..0x123E on 8 consecutive cycles; 8 i_fill_we with fill_word 0..7; i_done 11 cycles after first issue; i_busy low next cycle.
- d_miss=1, d_wr=1, d_addr=0x0040, d_wdata=0xBEEF -> single write at 0x0040 with data 0xBEEF; d_done on ack; no fill_we.
- i_miss and d_miss rise same cycle after reset (last_grant=I) -> D serviced first, then I granted; i_busy high throughout the D fill.
- Continuous d_miss refill requests alongside held i_miss -> grants alternate D, I, D; I is never skipped twice.
- rst pulled low at the 4th issue of an I fill, released, late mem_valid pulses arrive -> outputs 0, state IDLE, no fill_we; a new i_miss restarts at fill_word 0.
- d_miss fill at 0xFFF8 -> addresses 0xFFF0..0xFFFE, no wrap past 0xFFFE.
